encrypt_round_ctrl: RTL

// - Sequences the 3-round byte cipher: each round is XOR with key_r, then an 8-bit permutation.
// - One round per clock. Valid/ready handshake on both input and output.
// - Config mode uses a key/permutation table written through a config port.
// - Non-config mode uses the encrypt_config package defaults (keys DE/AD/BE, bit-reverse perm).
// - Sits between the byte-stream source and sink; the only owner of the round datapath.

---
 rtl/encrypt_round_ctrl_pkg.sv | 13 +
 rtl/encrypt_round.sv | 22 ++
 rtl/encrypt_round_ctrl.sv | 90 +++++++++
 3 files changed

// File: rtl/encrypt_round_ctrl_pkg.sv
// encrypt_config: shared types, round count and default key/permutation tables
package encrypt_config;
    localparam int N_ROUNDS = 3;
    localparam int DW = 8;
    localparam int PW = $clog2(DW);
    typedef enum logic [1:0] {IDLE, ROUND, DONE} ctrl_state_t;
    typedef logic [PW-1:0] perm_idx_t;
    typedef perm_idx_t [DW-1:0] perm_tbl_t;
    typedef logic [N_ROUNDS-1:0][DW-1:0] key_tbl_t;
    // element [0] is key1 / perm[0]
    localparam key_tbl_t DEFAULT_KEY = {8'hBE, 8'hAD, 8'hDE};
    localparam perm_tbl_t DEFAULT_PERM = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
endpackage

// File: rtl/encrypt_round.sv
// encrypt_round: one combinational cipher round, forward (xor, perm) or inverse (inv perm, xor)
module encrypt_round
    import encrypt_config::*;
(
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] key,
    input  perm_tbl_t     perm,
    input  logic          inv,
    output logic [DW-1:0] result
);
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    always_comb begin
        x = data ^ key;
        y = '0;
        for (int i = 0; i < DW; i++) begin
            if (inv) y[perm[i]] = data[i];
            else y[i] = x[perm[i]];
        end
        result = inv ? (y ^ key) : y;
    end
endmodule

// File: rtl/encrypt_round_ctrl.sv
// encrypt_round_ctrl: sequences the 3-round byte cipher with valid/ready on both sides
module encrypt_round_ctrl
    import encrypt_config::*;
(
    input  logic          clock,
    input  logic          n_reset,
    input  logic          cfg_mode,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [7:0]    cfg_wdata,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          decrypt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          cfg_err
);
    ctrl_state_t state;
    ctrl_state_t state_nx;
    logic [1:0] rnd;
    logic [1:0] kidx;
    logic [DW-1:0] dreg;
    logic [DW-1:0] rnext;
    logic dec;
    logic accept;
    logic last;
    key_tbl_t cfg_key;
    key_tbl_t key;
    perm_tbl_t cfg_perm;
    perm_tbl_t perm;

    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign out_valid = state == DONE;
    assign out_data  = out_valid ? dreg : '0;
    assign accept    = in_valid && in_ready;
    assign last      = rnd == 2'(N_ROUNDS - 1);
    assign kidx      = dec ? 2'(N_ROUNDS - 1) - rnd : rnd;

    encrypt_round u_round (
        .data   (dreg),
        .key    (key[kidx]),
        .perm   (perm),
        .inv    (dec),
        .result (rnext)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE && accept)    ? ROUND :
                   (state == ROUND && last)     ? DONE  :
                   (state == DONE && out_ready) ? IDLE  : state;
    end

    // the working table is snapshotted at accept so same-cycle writes only affect later bytes
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            dreg     <= '0;
            rnd      <= '0;
            dec      <= 1'b0;
            key      <= DEFAULT_KEY;
            perm     <= DEFAULT_PERM;
            cfg_key  <= DEFAULT_KEY;
            cfg_perm <= DEFAULT_PERM;
            cfg_err  <= 1'b0;
        end else begin
            if (accept) begin
                dreg <= in_data;
                dec  <= decrypt;
                rnd  <= '0;
                key  <= cfg_mode ? cfg_key : DEFAULT_KEY;
                perm <= cfg_mode ? cfg_perm : DEFAULT_PERM;
            end else if (state == ROUND) begin
                dreg <= rnext;
                rnd  <= rnd + 2'd1;
            end
            if (cfg_we && (busy || cfg_addr > 4'd10)) cfg_err <= 1'b1;
            else if (cfg_we && cfg_addr < 4'd3) cfg_key[cfg_addr[1:0]] <= cfg_wdata;
            else if (cfg_we) cfg_perm[3'(cfg_addr - 4'd3)] <= cfg_wdata[2:0];
        end
    end
endmodule
